axil_req_arbiter: RTL and testbench



---
 rtl/axil_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axil_req_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port between NUM_REQ
// single-beat requesters; one transaction in flight, response routed back to its owner.
module axil_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [32*NUM_REQ-1:0]        req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic [31:0]                  m_awaddr,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic                         m_bvalid,
  input  logic [1:0]                   m_bresp,
  output logic                         m_bready,
  output logic [31:0]                  m_araddr,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic [1:0]                   m_rresp,
  input  logic                         m_rvalid,
  output logic                         m_rready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                  state_reg;
  logic [IW-1:0]           last_reg;
  logic [IW-1:0]           owner_reg;
  logic [31:0]             addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic [NUM_REQ-1:0]      rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;

  logic [IW-1:0]           grant_idx;
  logic                    grant_found;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic [NUM_REQ-1:0]      owner_onehot;
  logic [31:0]             addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    unused_resp;

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp = ^{m_bresp[0], m_rresp[0]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]     = req_addr[32*gi +: 32];
      assign wdata_arr[gi]    = req_wdata[DATA_WIDTH*gi +: DATA_WIDTH];
      assign grant_onehot[gi] = grant_found && (grant_idx == IW'(gi));
      assign owner_onehot[gi] = (owner_reg == IW'(gi));
    end
  endgenerate

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IW-1:0];
  endfunction

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[rr_index(last_reg, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(last_reg, k);
      end
    end
  end

  // Gated with aresetn so no accept is offered while reset is held.
  assign req_ready = (state_reg == IDLE && aresetn) ? grant_onehot : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      last_reg      <= IW'(NUM_REQ - 1);
      owner_reg     <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            owner_reg <= grant_idx;
            last_reg  <= grant_idx;
            addr_reg  <= addr_arr[grant_idx];
            wdata_reg <= wdata_arr[grant_idx];
            if (req_write[grant_idx]) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_awready) awvalid_reg <= 1'b0;
          if (m_wready) wvalid_reg <= 1'b0;
          // Address and data handshakes may land together or in either order.
          if ((!awvalid_reg || m_awready) && (!wvalid_reg || m_wready)) begin
            bready_reg <= 1'b1;
            state_reg  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            bready_reg    <= 1'b0;
            err_reg       <= m_bresp[1];
            rdata_reg     <= '0;
            rsp_valid_reg <= owner_onehot;
            state_reg     <= RSP;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_rvalid) begin
            rready_reg    <= 1'b0;
            rdata_reg     <= m_rdata;
            err_reg       <= m_rresp[1];
            rsp_valid_reg <= owner_onehot;
            state_reg     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_awaddr  = addr_reg;
  assign m_araddr  = addr_reg;
  assign m_wdata   = wdata_reg;
  assign m_awvalid = awvalid_reg;
  assign m_wvalid  = wvalid_reg;
  assign m_bready  = bready_reg;
  assign m_arvalid = arvalid_reg;
  assign m_rready  = rready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter with a transaction-level reference model
// checked every cycle on the falling clock edge.
module tb_axil_req_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;

  logic              aclk;
  logic              aresetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_write;
  logic [32*N-1:0]   req_addr;
  logic [DW*N-1:0]   req_wdata;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [31:0]       m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DW-1:0]     m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic              m_bvalid;
  logic [1:0]        m_bresp;
  logic              m_bready;
  logic [31:0]       m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  axil_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // reference model state
  bit          busy = 0, mwrite = 0, aw_done = 0, w_done = 0, ar_done = 0, resp_done = 0;
  int          owner = 0, mlast = N - 1;
  logic [31:0] maddr = 0, mdata = 0, exp_rdata = 0;
  logic        exp_err = 0;
  int          grant_log[$];
  int          aw_hs_n = 0, w_hs_n = 0, awv_cyc = 0, wv_cyc = 0;

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI-Lite slave: each ready/valid answer comes a programmable number of cycles late.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (m_awvalid) begin m_awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin m_awready = 0; aw_cnt = 0; end
      if (m_wvalid) begin m_wready = (w_cnt >= w_delay); w_cnt++; end
      else begin m_wready = 0; w_cnt = 0; end
      if (m_bready) begin m_bvalid = (b_cnt >= b_delay); b_cnt++; end
      else begin m_bvalid = 0; b_cnt = 0; end
      if (m_arvalid) begin m_arready = (ar_cnt >= ar_delay); ar_cnt++; end
      else begin m_arready = 0; ar_cnt = 0; end
      if (m_rready) begin m_rvalid = (r_cnt >= r_delay); r_cnt++; end
      else begin m_rvalid = 0; r_cnt = 0; end
      m_bresp = cfg_bresp;
      m_rresp = cfg_rresp;
      m_rdata = cfg_rdata;
    end
  end

  // Transaction-level model: idle -> grant -> channel phases -> response -> idle.
  initial begin
    logic [N-1:0] exp_rr;
    logic [N-1:0] exp_rsp;
    int eg;
    bit in_rsp;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        check("reset_valids", {req_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_err}, 0);
        check("reset_regs", {m_awaddr, m_araddr}, 0);
        check("reset_data", {m_wdata, rsp_rdata}, 0);
        busy = 0; mlast = N - 1; resp_done = 0;
      end else begin
        eg = -1;
        exp_rr = '0;
        if (!busy) begin
          for (int k = 1; k <= N; k++)
            if (eg < 0 && req_valid[(mlast + k) % N]) eg = (mlast + k) % N;
          if (eg >= 0) exp_rr[eg] = 1'b1;
        end
        in_rsp = busy && resp_done;
        exp_rsp = '0;
        if (in_rsp) exp_rsp[owner] = 1'b1;
        check("req_ready", req_ready, exp_rr);
        check("axi_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
              {busy && mwrite && !aw_done, busy && mwrite && !w_done,
               busy && mwrite && aw_done && w_done && !resp_done,
               busy && !mwrite && !ar_done, busy && !mwrite && ar_done && !resp_done});
        check("rsp_valid", rsp_valid, exp_rsp);
        if (busy) begin
          check("m_awaddr", m_awaddr, maddr);
          check("m_araddr", m_araddr, maddr);
          if (mwrite) check("m_wdata", m_wdata, mdata);
        end
        if (in_rsp) begin
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", rsp_err, exp_err);
        end
        if (m_awvalid) awv_cyc++;
        if (m_wvalid) wv_cyc++;
        if (m_awvalid && m_awready) aw_hs_n++;
        if (m_wvalid && m_wready) w_hs_n++;
        if (busy) begin
          if (m_awvalid && m_awready) aw_done = 1;
          if (m_wvalid && m_wready) w_done = 1;
          if (m_arvalid && m_arready) ar_done = 1;
          if (m_bvalid && m_bready) begin resp_done = 1; exp_rdata = 0; exp_err = m_bresp[1]; end
          if (m_rvalid && m_rready) begin resp_done = 1; exp_rdata = m_rdata; exp_err = m_rresp[1]; end
          if (in_rsp && rsp_ready[owner]) busy = 0;
        end else if (eg >= 0) begin
          busy = 1; owner = eg; mlast = eg;
          mwrite = req_write[eg];
          maddr = req_addr[32*eg +: 32];
          mdata = req_wdata[32*eg +: 32];
          aw_done = 0; w_done = 0; ar_done = 0; resp_done = 0;
          grant_log.push_back(eg);
        end
      end
    end
  end

  task automatic set_req(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[32*r +: 32] = a;
    req_wdata[32*r +: 32] = d;
  endtask

  task automatic wait_grant(input int r, output int gc);
    bit found;
    found = 0;
    gc = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge aclk);
      if (req_valid[r] && req_ready[r]) begin found = 1; gc = cyc; end
    end
    check($sformatf("grant_seen_req%0d", r), found, 1);
    @(posedge aclk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, output logic [31:0] rd, output logic er, output int rc);
    bit found;
    found = 0;
    rc = -1; rd = 'x; er = 'x;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge aclk);
      if (rsp_valid[r] && rsp_ready[r]) begin found = 1; rc = cyc; rd = rsp_rdata; er = rsp_err; end
    end
    check($sformatf("rsp_seen_req%0d", r), found, 1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int g, g2, rc, k, base, aw0, w0, awc0, wc0;
    bit seen;
    logic [31:0] rd;
    logic er;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '1;
    aresetn = 1;
    #3 aresetn = 0;
    #1;
    req_valid = 3'b111;
    #1;
    check("init_reset_req_ready", req_ready, 0);
    check("init_reset_valids", {rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_err}, 0);
    check("init_reset_rdata", rsp_rdata, 0);
    check("init_reset_awaddr", m_awaddr, 0);
    req_valid = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    repeat (2) @(posedge aclk);
    #1;

    // single write, best-case slave
    set_req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_grant(0, g);
    wait_rsp(0, rd, er, rc);
    $display("write req0 addr=00000010 grant_cycle=%0d rsp_cycle=%0d rdata=%h err=%0d", g, rc, rd, er);
    check("wr_latency", rc - g, 3);
    check("wr_rdata", rd, 32'h0);
    check("wr_err", er, 0);
    check("wr_awaddr_held", m_awaddr, 32'h0000_0010);
    check("wr_wdata_held", m_wdata, 32'hDEAD_BEEF);

    // read with stalling slave
    ar_delay = 3; r_delay = 1; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    set_req(1, 0, 32'h0000_0020, 32'h0);
    wait_grant(1, g);
    wait_rsp(1, rd, er, rc);
    $display("read  req1 addr=00000020 grant_cycle=%0d rsp_cycle=%0d rdata=%h err=%0d", g, rc, rd, er);
    check("rd_latency", rc - g, 7);
    check("rd_rdata", rd, 32'h1234_5678);
    check("rd_err", er, 1);
    check("rd_araddr_held", m_araddr, 32'h0000_0020);
    ar_delay = 0; r_delay = 0; cfg_rresp = 2'b00;

    // split write handshake: wready 4 cycles ahead of awready
    aw_delay = 4;
    aw0 = aw_hs_n; w0 = w_hs_n; awc0 = awv_cyc; wc0 = wv_cyc;
    set_req(2, 1, 32'h0000_0030, 32'hA5A5_0F0F);
    wait_grant(2, g);
    wait_rsp(2, rd, er, rc);
    $display("write req2 addr=00000030 split grant_cycle=%0d rsp_cycle=%0d err=%0d", g, rc, er);
    check("split_latency", rc - g, 7);
    check("split_aw_handshakes", aw_hs_n - aw0, 1);
    check("split_w_handshakes", w_hs_n - w0, 1);
    check("split_awvalid_cycles", awv_cyc - awc0, 5);
    check("split_wvalid_cycles", wv_cyc - wc0, 1);
    aw_delay = 0;

    // round-robin fairness with all three requesters pending
    base = grant_log.size();
    set_req(0, 1, 32'h0000_0100, 32'h0000_00A0);
    set_req(1, 0, 32'h0000_0104, 32'h0);
    set_req(2, 1, 32'h0000_0108, 32'h0000_00A2);
    for (int i = 0; i < 300 && grant_log.size() < base + 6; i++) @(negedge aclk);
    @(posedge aclk);
    #1 req_valid = '0;
    repeat (20) @(posedge aclk);
    #1;
    check("rr_grant_count", grant_log.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < grant_log.size()) begin
        $display("fairness grant %0d -> req%0d", i, grant_log[base + i]);
        check($sformatf("rr_order%0d", i), grant_log[base + i], i % 3);
      end
    end

    // response backpressure on req0 while req1 waits
    cfg_rdata = 32'hCAFE_F00D;
    rsp_ready[0] = 1'b0;
    set_req(0, 0, 32'h0000_0040, 32'h0);
    wait_grant(0, g);
    set_req(1, 1, 32'h0000_0044, 32'h55AA_55AA);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge aclk);
      if (rsp_valid[0]) seen = 1;
    end
    check("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 3'b001);
      check("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
      check("bp_req_ready", req_ready, 0);
      check("bp_axi_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
      if (i < 4) @(negedge aclk);
    end
    @(posedge aclk);
    #1 rsp_ready[0] = 1'b1;
    k = cyc;
    wait_grant(1, g2);
    $display("backpressure rsp0 rdata=%h released cycle=%0d req1 grant_cycle=%0d", rsp_rdata, k, g2);
    check("bp_req1_grant_cycle", g2, k + 1);
    wait_rsp(1, rd, er, rc);
    check("bp_req1_err", er, 0);

    // reset while waiting in the write-response phase
    b_delay = 6;
    set_req(0, 1, 32'h0000_0050, 32'h1111_2222);
    wait_grant(0, g);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      if (m_bready) seen = 1;
    end
    check("rst_bready_seen", seen, 1);
    #2 aresetn = 0;
    #1;
    check("rst_async_valids", {rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_err}, 0);
    check("rst_async_awaddr", m_awaddr, 0);
    set_req(0, 1, 32'h0000_0060, 32'h0000_0006);
    set_req(1, 1, 32'h0000_0064, 32'h0000_0007);
    #1;
    check("rst_async_req_ready", req_ready, 0);
    b_delay = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    k = cyc;
    base = grant_log.size();
    wait_grant(0, g);
    $display("reset release cycle=%0d first grant req%0d at cycle %0d", k,
             (grant_log.size() > base) ? grant_log[base] : -1, g);
    check("rst_first_grant_cycle", g, k);
    if (grant_log.size() > base) check("rst_first_grant_req", grant_log[base], 0);
    else check("rst_first_grant_logged", grant_log.size(), base + 1);
    wait_rsp(0, rd, er, rc);
    wait_grant(1, g);
    wait_rsp(1, rd, er, rc);
    check("rst_after_err", er, 0);

    repeat (5) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
